// File: rtl/lane_expand_pkg.sv
// lane_expand_seq shared types, widths and per-slot helpers.
// Optional LANE_EXPAND_SEQ_STATS_EN adds beat/pad counters on the top.
package lane_expand_pkg;

  localparam int BSW = 5;
  localparam int BS  = 1 << BSW;
  localparam int NE  = 32;
  localparam int LW  = 8 - BSW + 1;

  function automatic int ew_of(input int ne);
    return (ne > 1) ? $clog2(ne) : 1;
  endfunction

  function automatic int tw_of(input int ne, input int lw);
    return $clog2(ne * ((1 << lw) - 1) + 1);
  endfunction

  localparam int EW = ew_of(NE);
  localparam int TW = tw_of(NE, LW);
  localparam int BW = TW - BSW;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

  typedef struct packed {
    logic           pad;
    logic [BSW-1:0] off;
  } slot_t;

  // k is the slot's index inside its element; offset wraps modulo BS
  function automatic slot_t slot_calc(
    input logic [TW-1:0]  k,
    input logic [BSW-1:0] pos,
    input logic [LW-1:0]  len
  );
    slot_t r;
    r.off = pos + k[BSW-1:0];
    r.pad = (k >= TW'(len));
    return r;
  endfunction

endpackage

// File: rtl/lane_expand_seq_if.sv
// Batch-in / beat-out handshake bundle for lane_expand_seq.
// slave is the block's view, master the producer/consumer view.
interface lane_expand_seq_if;
  import lane_expand_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [EW:0]            in_num;
  logic [NE-1:0][LW-1:0]  in_alen;
  logic [NE-1:0][LW-1:0]  in_len;
  logic [NE-1:0][BSW-1:0] in_pos;

  logic                   out_valid;
  logic                   out_ready;
  logic [BS-1:0]          out_mask;
  logic [BS-1:0][EW-1:0]  out_eidx;
  logic [BS-1:0][BSW-1:0] out_off;
  logic [BS-1:0]          out_pad;
  logic                   out_last;
  logic [BW-1:0]          out_beat;

  modport slave (
    input  in_valid, in_num, in_alen, in_len, in_pos,
    output in_ready,
    output out_valid, out_mask, out_eidx, out_off,
    output out_pad, out_last, out_beat,
    input  out_ready
  );

  modport master (
    output in_valid, in_num, in_alen, in_len, in_pos,
    input  in_ready,
    input  out_valid, out_mask, out_eidx, out_off,
    input  out_pad, out_last, out_beat,
    output out_ready
  );

endinterface

// File: rtl/lane_psum.sv
// Combinational inclusive prefix adder over per-element slot counts.
// Optional stats (LANE_EXPAND_SEQ_STATS_EN) do not affect this block.
module lane_psum
  import lane_expand_pkg::*;
(
  input  logic [NE-1:0][LW-1:0] alen,
  output logic [NE-1:0][TW-1:0] psum
);

  logic [TW-1:0] acc;

  always_comb begin
    acc  = '0;
    psum = '0;
    for (int j = 0; j < NE; j++) begin
      acc     = acc + TW'(alen[j]);
      psum[j] = acc;
    end
  end

endmodule

// File: rtl/lane_expand_seq.sv
// Streams the expanded slot map of a batch as BS-slot beats.
// Define LANE_EXPAND_SEQ_STATS_EN for stat_beats/stat_pad counters.
module lane_expand_seq
  import lane_expand_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  lane_expand_seq_if.slave bus
`ifdef LANE_EXPAND_SEQ_STATS_EN
  ,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_pad
`endif
);

  state_t state, state_nx;

  logic [NE-1:0][LW-1:0]  alen_in, len_in;
  logic [NE-1:0][LW-1:0]  alen_q, len_q;
  logic [NE-1:0][BSW-1:0] pos_q;
  logic [NE-1:0][TW-1:0]  psum_c, psum_q, prev;
  logic [TW-1:0]          total_q, tm1, g;
  logic [BW-1:0]          lastb_q, beat_q, lastb_nx;
  logic                   accept, fire, last, emit;
  slot_t                  sl;

  logic [BS-1:0]          mask, pad;
  logic [BS-1:0][EW-1:0]  eidx;
  logic [BS-1:0][BSW-1:0] off;

  lane_psum u_psum (
    .alen (alen_q),
    .psum (psum_c)
  );

  assign emit     = (state == EMIT);
  assign accept   = (state == IDLE) && bus.in_valid;
  assign last     = (beat_q == lastb_q);
  assign fire     = emit && bus.out_ready;
  assign tm1      = psum_c[NE-1] - TW'(1);
  assign lastb_nx = (psum_c[NE-1] == '0) ? '0 : BW'(tm1 >> BSW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = SCAN;
      end
      SCAN: state_nx = EMIT;
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // drop elements past in_num and clamp len to the allocation
  always_comb begin
    alen_in = '0;
    len_in  = '0;
    for (int j = 0; j < NE; j++) begin
      if ((EW+1)'(j) < bus.in_num) alen_in[j] = bus.in_alen[j];
      len_in[j] = (bus.in_len[j] > alen_in[j]) ? alen_in[j]
                                               : bus.in_len[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alen_q  <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      psum_q  <= '0;
      total_q <= '0;
      lastb_q <= '0;
      beat_q  <= '0;
    end else begin
      if (accept) begin
        alen_q <= alen_in;
        len_q  <= len_in;
        pos_q  <= bus.in_pos;
      end
      if (state == SCAN) begin
        psum_q  <= psum_c;
        total_q <= psum_c[NE-1];
        lastb_q <= lastb_nx;
        beat_q  <= '0;
      end
      if (fire && !last) beat_q <= beat_q + 1'b1;
    end
  end

  always_comb begin
    prev = '0;
    for (int j = 1; j < NE; j++) prev[j] = psum_q[j-1];
  end

  // zero-alen elements have prev==psum and can never match
  always_comb begin
    mask = '0;
    pad  = '0;
    eidx = '0;
    off  = '0;
    g    = '0;
    sl   = '0;
    if (emit) begin
      for (int s = 0; s < BS; s++) begin
        g = {beat_q, BSW'(s)};
        for (int j = 0; j < NE; j++) begin
          if (g < total_q && g >= prev[j] && g < psum_q[j]) begin
            sl      = slot_calc(g - prev[j], pos_q[j], len_q[j]);
            mask[s] = 1'b1;
            eidx[s] = EW'(j);
            off[s]  = sl.off;
            pad[s]  = sl.pad;
          end
        end
      end
    end
  end

  assign bus.out_mask = mask;
  assign bus.out_pad  = pad;
  assign bus.out_eidx = eidx;
  assign bus.out_off  = off;
  assign bus.out_last = emit && last;
  assign bus.out_beat = emit ? beat_q : '0;

`ifdef LANE_EXPAND_SEQ_STATS_EN
  logic [31:0] pad_cnt;
  logic [32:0] pad_sum;

  assign pad_cnt = 32'($countones(pad));
  assign pad_sum = {1'b0, stat_pad} + {1'b0, pad_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_pad   <= '0;
    end else if (fire) begin
      if (!(&stat_beats)) stat_beats <= stat_beats + 32'd1;
      stat_pad <= pad_sum[32] ? '1 : pad_sum[31:0];
    end
  end
`endif

endmodule
